net_iface: RTL and testbench



---
 rtl/net_iface.sv | 229 ++++++++++++++++++++++
 tb/tb_net_iface.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_iface.sv
// net_iface: tile-side network interface at the router LOCAL port.
// Outbound flits are queued in a TX FIFO and injected with one-cycle req
// pulses, retried after a backoff when no ack returns. Ejected flits are
// accepted into an RX FIFO and delivered on a valid/ready port.
// Optional feature macro: NI_RETRY_LIMIT_EN (drop the head flit and set
// tx_err after MAX_RETRIES failed attempts). Undefined: retry forever.
//
// TX FSM states:
//   state     | meaning
//   S_IDLE    | TX FIFO empty, nothing to inject
//   S_SEND    | req_out high for this single cycle, head flit on flit_out_*
//   S_WAIT    | ack_in sampled; ack pops the head, no ack schedules a retry
//   S_BACKOFF | idle BACKOFF cycles before resending the same head flit
module net_iface #(
    parameter int TILE_ID     = 0,
    parameter int NUM_TILES   = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int PRI_WIDTH   = 2,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4,
    parameter int BACKOFF     = 2,
    parameter int MAX_RETRIES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [ADDR_WIDTH-1:0] tx_addr,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [PRI_WIDTH-1:0]  tx_pri,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] rx_addr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [PRI_WIDTH-1:0]  rx_pri,
    output logic                  req_out,
    output logic [ADDR_WIDTH-1:0] flit_out_addr,
    output logic [DATA_WIDTH-1:0] flit_out_data,
    output logic [PRI_WIDTH-1:0]  flit_out_pri,
    input  logic                  ack_in,
    input  logic                  req_in,
    input  logic [ADDR_WIDTH-1:0] flit_in_addr,
    input  logic [DATA_WIDTH-1:0] flit_in_data,
    input  logic [PRI_WIDTH-1:0]  flit_in_pri,
    output logic                  ack_out,
    output logic                  tx_err,
    output logic                  rx_misroute,
    output logic [7:0]            rx_drop_cnt
);

    localparam int TX_PW = $clog2(TX_DEPTH) + 1;
    localparam int RX_PW = $clog2(RX_DEPTH) + 1;
    localparam logic [3:0] BO_LOAD = 4'((BACKOFF > 0) ? BACKOFF - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_BACKOFF} state_t;

    state_t r_state;
    logic   r_req_out;
    logic [3:0] r_bo_cnt;

    logic [ADDR_WIDTH-1:0] r_tx_addr [TX_DEPTH];
    logic [DATA_WIDTH-1:0] r_tx_data [TX_DEPTH];
    logic [PRI_WIDTH-1:0]  r_tx_pri  [TX_DEPTH];
    logic [TX_PW-1:0]      r_tx_wptr, r_tx_rptr;

    logic [ADDR_WIDTH-1:0] r_rx_addr [RX_DEPTH];
    logic [DATA_WIDTH-1:0] r_rx_data [RX_DEPTH];
    logic [PRI_WIDTH-1:0]  r_rx_pri  [RX_DEPTH];
    logic [RX_PW-1:0]      r_rx_wptr, r_rx_rptr;

    logic       r_ack_out;
    logic       r_rx_misroute;
    logic [7:0] r_rx_drop_cnt;

    logic             w_tx_full, w_tx_empty, w_tx_push, w_tx_more, w_tx_done;
    logic [TX_PW-1:0] w_tx_cnt;
    logic             w_retry_exh;
    logic             w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
    logic [31:0]      w_rx_dest;
    logic             w_unused;

    assign w_tx_full  = (r_tx_wptr[TX_PW-1] != r_tx_rptr[TX_PW-1]) &&
                        (r_tx_wptr[TX_PW-2:0] == r_tx_rptr[TX_PW-2:0]);
    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_push  = tx_valid && !w_tx_full;
    assign w_tx_cnt   = r_tx_wptr - r_tx_rptr;
    // another flit stays queued after the head leaves, so go straight to SEND
    assign w_tx_more  = (w_tx_cnt > TX_PW'(1));
    // head leaves the FIFO: accepted by the router, or abandoned after the retry limit
    assign w_tx_done  = (r_state == S_WAIT) && (ack_in || w_retry_exh);

    assign tx_ready      = !w_tx_full;
    assign req_out       = r_req_out;
    // flit_out is zero while nothing is queued so the link idles clean
    assign flit_out_addr = w_tx_empty ? '0 : r_tx_addr[r_tx_rptr[TX_PW-2:0]];
    assign flit_out_data = w_tx_empty ? '0 : r_tx_data[r_tx_rptr[TX_PW-2:0]];
    assign flit_out_pri  = w_tx_empty ? '0 : r_tx_pri[r_tx_rptr[TX_PW-2:0]];

`ifdef NI_RETRY_LIMIT_EN
    localparam int RW = $clog2(MAX_RETRIES + 1);
    logic [RW-1:0] r_retry_cnt;
    logic          r_tx_err;

    assign w_retry_exh = (r_retry_cnt == RW'(MAX_RETRIES - 1));
    assign tx_err      = r_tx_err;

    // count failed attempts on the current head; flag when one is abandoned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry_cnt <= '0;
            r_tx_err    <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (ack_in || w_retry_exh) r_retry_cnt <= '0;
            else                       r_retry_cnt <= r_retry_cnt + 1'b1;
            if (!ack_in && w_retry_exh) r_tx_err <= 1'b1;
        end
    end
`else
    localparam int unused_max_retries = MAX_RETRIES;
    assign w_retry_exh = 1'b0;
    assign tx_err      = 1'b0;
`endif

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_addr[r_tx_wptr[TX_PW-2:0]] <= tx_addr;
            r_tx_data[r_tx_wptr[TX_PW-2:0]] <= tx_data;
            r_tx_pri[r_tx_wptr[TX_PW-2:0]]  <= tx_pri;
        end
    end

    // TX FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_done) r_tx_rptr <= r_tx_rptr + 1'b1;
        end
    end

    // TX injection FSM; req_out is raised on every entry into S_SEND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_req_out <= 1'b0;
            r_bo_cnt  <= '0;
        end else begin
            r_req_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_tx_empty) begin
                        r_state   <= S_SEND;
                        r_req_out <= 1'b1;
                    end
                end
                S_SEND: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_tx_done) begin
                        r_state   <= w_tx_more ? S_SEND : S_IDLE;
                        r_req_out <= w_tx_more;
                    end else if (BACKOFF == 0) begin
                        r_state   <= S_SEND;
                        r_req_out <= 1'b1;
                    end else begin
                        r_state  <= S_BACKOFF;
                        r_bo_cnt <= BO_LOAD;
                    end
                end
                S_BACKOFF: begin
                    if (r_bo_cnt == 4'd0) begin
                        r_state   <= S_SEND;
                        r_req_out <= 1'b1;
                    end else begin
                        r_bo_cnt <= r_bo_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_rx_full  = (r_rx_wptr[RX_PW-1] != r_rx_rptr[RX_PW-1]) &&
                        (r_rx_wptr[RX_PW-2:0] == r_rx_rptr[RX_PW-2:0]);
    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_push  = req_in && !w_rx_full;
    assign w_rx_pop   = !w_rx_empty && rx_ready;
    assign w_rx_dest  = 32'(flit_in_addr[4:0]) % 32'(NUM_TILES);
    assign w_unused   = ^flit_in_addr[ADDR_WIDTH-1:5];

    assign rx_valid    = !w_rx_empty;
    assign rx_addr     = r_rx_addr[r_rx_rptr[RX_PW-2:0]];
    assign rx_data     = r_rx_data[r_rx_rptr[RX_PW-2:0]];
    assign rx_pri      = r_rx_pri[r_rx_rptr[RX_PW-2:0]];
    assign ack_out     = r_ack_out;
    assign rx_misroute = r_rx_misroute;
    assign rx_drop_cnt = r_rx_drop_cnt;

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_addr[r_rx_wptr[RX_PW-2:0]] <= flit_in_addr;
            r_rx_data[r_rx_wptr[RX_PW-2:0]] <= flit_in_data;
            r_rx_pri[r_rx_wptr[RX_PW-2:0]]  <= flit_in_pri;
        end
    end

    // RX pointers, ack pulse, misroute flag and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wptr     <= '0;
            r_rx_rptr     <= '0;
            r_ack_out     <= 1'b0;
            r_rx_misroute <= 1'b0;
            r_rx_drop_cnt <= '0;
        end else begin
            r_ack_out <= w_rx_push;
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            if (w_rx_push && (w_rx_dest != 32'(TILE_ID))) r_rx_misroute <= 1'b1;
            if (req_in && w_rx_full && (r_rx_drop_cnt != 8'hFF))
                r_rx_drop_cnt <= r_rx_drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_net_iface.sv
// Self-checking bench for net_iface: reset values, TX injection/retry/fill,
// RX table vectors, RX overflow and drop saturation, async reset mid-stream.
module tb_net_iface;
    localparam int AW = 32, DW = 32, PW = 2;
    localparam int BO = 2, MAXR = 8;
`ifdef NI_RETRY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic tx_valid = 1'b0, tx_ready;
    logic [AW-1:0] tx_addr = '0; logic [DW-1:0] tx_data = '0; logic [PW-1:0] tx_pri = '0;
    logic rx_valid, rx_ready = 1'b0;
    logic [AW-1:0] rx_addr; logic [DW-1:0] rx_data; logic [PW-1:0] rx_pri;
    logic req_out, ack_in = 1'b0, req_in = 1'b0, ack_out;
    logic [AW-1:0] flit_out_addr; logic [DW-1:0] flit_out_data; logic [PW-1:0] flit_out_pri;
    logic [AW-1:0] flit_in_addr = '0; logic [DW-1:0] flit_in_data = '0; logic [PW-1:0] flit_in_pri = '0;
    logic tx_err, rx_misroute;
    logic [7:0] rx_drop_cnt;

    net_iface #(.TILE_ID(0), .NUM_TILES(16), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRI_WIDTH(PW),
                .TX_DEPTH(4), .RX_DEPTH(4), .BACKOFF(BO), .MAX_RETRIES(MAXR)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_addr(tx_addr), .tx_data(tx_data), .tx_pri(tx_pri),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_addr(rx_addr), .rx_data(rx_data), .rx_pri(rx_pri),
        .req_out(req_out), .flit_out_addr(flit_out_addr), .flit_out_data(flit_out_data),
        .flit_out_pri(flit_out_pri), .ack_in(ack_in),
        .req_in(req_in), .flit_in_addr(flit_in_addr), .flit_in_data(flit_in_data),
        .flit_in_pri(flit_in_pri), .ack_out(ack_out),
        .tx_err(tx_err), .rx_misroute(rx_misroute), .rx_drop_cnt(rx_drop_cnt));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [PW-1:0] pri;
    } flit_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [PW-1:0] pri;
        logic          exp_mis;
    } rx_vec_t;

    flit_t exp_tx[$];
    flit_t exp_rx[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // TX monitor state
    int   ack_at = 0;      // ack the attempt with this number (0 = never)
    int   attempt = 0;
    int   pulses = 0;
    int   first_pc = 0, last_pc = 0, since = 0;
    logic ack_next = 1'b0;
    logic exp_tx_err = 1'b0;

    function automatic flit_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [PW-1:0] p);
        flit_t f;
        f.addr = a; f.data = d; f.pri = p;
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input flit_t f, input bit stored);
        tx_valid = 1'b1; tx_addr = f.addr; tx_data = f.data; tx_pri = f.pri;
        if (stored) exp_tx.push_back(f);
        step();
        tx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tx_valid = 1'b0; req_in = 1'b0; ack_at = 0; ack_next = 1'b0;
        exp_tx.delete(); exp_rx.delete(); attempt = 0; exp_tx_err = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Scoreboard on the router side: every req_out pulse must carry the queue head;
    // decides whether to ack it in the following (WAIT) cycle.
    initial forever begin
        @(posedge clk);
        #2;
        ack_in = ack_next;
        ack_next = 1'b0;
        since++;
        if (rst_n && req_out) begin
            pulses++;
            attempt++;
            if (pulses == 1) first_pc = cyc;
            last_pc = cyc;
            if (attempt > 1) check("retry_gap", since, BO + 2);
            since = 0;
            check("pulse_has_queued_flit", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) begin
                check("flit_out_addr", flit_out_addr, exp_tx[0].addr);
                check("flit_out_data", flit_out_data, exp_tx[0].data);
                check("flit_out_pri", flit_out_pri, exp_tx[0].pri);
                if (ack_at != 0 && attempt >= ack_at) begin
                    ack_next = 1'b1;
                    void'(exp_tx.pop_front());
                    attempt = 0;
                end else if (LIMIT && attempt == MAXR) begin
                    void'(exp_tx.pop_front());
                    attempt = 0;
                    exp_tx_err = 1'b1;
                end
            end
        end
    end

    initial begin
        rx_vec_t vec[5];
        flit_t   f;
        int      push_c, acks, mcnt, exp_drops, ndrain;

        vec[0] = '{32'h0,  32'h1111_0000, 2'd0, 1'b0};
        vec[1] = '{32'h10, 32'h2222_0001, 2'd1, 1'b0};
        vec[2] = '{32'h20, 32'h3333_0002, 2'd2, 1'b0};
        vec[3] = '{32'h5,  32'hDEAD_BEEF, 2'd3, 1'b1};
        vec[4] = '{32'h30, 32'h5555_0004, 2'd1, 1'b1};

        // reset values
        #3;
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_req_out", req_out, 0);
        check("rst_ack_out", ack_out, 0);
        check("rst_flit_out_addr", flit_out_addr, 0);
        check("rst_flit_out_data", flit_out_data, 0);
        check("rst_flit_out_pri", flit_out_pri, 0);
        check("rst_tx_err", tx_err, 0);
        check("rst_rx_misroute", rx_misroute, 0);
        check("rst_rx_drop_cnt", rx_drop_cnt, 0);
        do_reset();

        // single flit acked on first attempt
        pulses = 0; ack_at = 1;
        push_c = cyc;
        push_tx(mk(32'h3, 32'hA5, 2'd1), 1'b1);
        repeat (10) step();
        check("t1_pulses", pulses, 1);
        check("t1_latency", first_pc - push_c, 2);
        check("t1_queue_empty", exp_tx.size(), 0);
        check("t1_tx_ready", tx_ready, 1);

        // three missed acks, accepted on the fourth attempt
        pulses = 0; ack_at = 4;
        push_tx(mk(32'h7, 32'hCAFE, 2'd2), 1'b1);
        repeat (30) step();
        check("t2_pulses", pulses, 4);
        check("t2_queue_empty", exp_tx.size(), 0);
        check("t2_tx_ready", tx_ready, 1);

        // back-to-back flits: one per 2 cycles
        pulses = 0; ack_at = 1;
        for (int i = 0; i < 3; i++) push_tx(mk(32'(i + 1), 32'h100 + 32'(i), 2'(i)), 1'b1);
        repeat (15) step();
        check("t3_pulses", pulses, 3);
        check("t3_span", last_pc - first_pc, 4);
        check("t3_queue_empty", exp_tx.size(), 0);

        // fill with no ack, push while full is discarded
        pulses = 0; ack_at = 0;
        for (int i = 0; i < 4; i++) push_tx(mk(32'h40 + 32'(i), 32'h200 + 32'(i), 2'd3), 1'b1);
        check("t4_full_tx_ready", tx_ready, 0);
        push_tx(mk(32'h99, 32'hBAD, 2'd0), 1'b0);
        check("t4_still_full", tx_ready, 0);
        ack_at = 1;
        repeat (40) step();
        check("t4_queue_empty", exp_tx.size(), 0);
        check("t4_tx_ready", tx_ready, 1);

        // retry limit behaviour
        pulses = 0; ack_at = 0;
        push_tx(mk(32'h8, 32'hAAAA, 2'd1), 1'b1);
        push_tx(mk(32'h9, 32'hBBBB, 2'd2), 1'b1);
`ifdef NI_RETRY_LIMIT_EN
        repeat (40) step();
        check("t5_tx_err_set", tx_err, 1);
        check("t5_first_dropped", exp_tx.size(), 1);
`else
        repeat (60) step();
        check("t5_tx_err_zero", tx_err, 0);
        check("t5_keeps_retrying", pulses > MAXR, 1);
`endif
        ack_at = 1;
        repeat (30) step();
        check("t5_tx_err_model", tx_err, exp_tx_err);
        check("t5_queue_empty", exp_tx.size(), 0);

        // RX table vectors
        do_reset();
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_in = 1'b1;
            flit_in_addr = vec[i].addr; flit_in_data = vec[i].data; flit_in_pri = vec[i].pri;
            exp_rx.push_back(mk(vec[i].addr, vec[i].data, vec[i].pri));
            step();
            req_in = 1'b0;
            check("rx_ack_pulse", ack_out, 1);
            check("rx_valid", rx_valid, 1);
            f = exp_rx.pop_front();
            check("rx_addr", rx_addr, f.addr);
            check("rx_data", rx_data, f.data);
            check("rx_pri", rx_pri, f.pri);
            check("rx_misroute", rx_misroute, vec[i].exp_mis);
            step();
            check("rx_ack_single", ack_out, 0);
            check("rx_drained", rx_valid, 0);
        end

        // RX overflow: 6 offers into a 4-deep FIFO with rx_ready low
        do_reset();
        rx_ready = 1'b0; acks = 0; mcnt = 0; exp_drops = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                req_in = 1'b1;
                flit_in_addr = 32'(i) << 4; flit_in_data = 32'h600 + 32'(i); flit_in_pri = 2'(i);
                if (mcnt < 4) begin
                    exp_rx.push_back(mk(32'(i) << 4, 32'h600 + 32'(i), 2'(i)));
                    mcnt++;
                end else exp_drops++;
            end else req_in = 1'b0;
            step();
            acks += int'(ack_out);
        end
        check("ovf_ack_count", acks, 4);
        check("ovf_drop_cnt", rx_drop_cnt, exp_drops);
        rx_ready = 1'b1; ndrain = 0;
        for (int k = 0; k < 8; k++) begin
            if (rx_valid) begin
                f = exp_rx.pop_front();
                check("drain_addr", rx_addr, f.addr);
                check("drain_data", rx_data, f.data);
                ndrain++;
            end
            step();
        end
        check("drain_count", ndrain, 4);
        check("drain_empty", rx_valid, 0);

        // drop counter saturation
        rx_ready = 1'b0; req_in = 1'b1; flit_in_addr = '0;
        for (int i = 0; i < 264; i++) begin
            if (i >= 4 && exp_drops < 255) exp_drops++;
            step();
        end
        req_in = 1'b0;
        check("drop_saturate", rx_drop_cnt, exp_drops);
        check("no_ack_when_full", ack_out, 0);

        // misroute plus async reset mid-stream
        do_reset();
        rx_ready = 1'b0; ack_at = 0;
        req_in = 1'b1; flit_in_addr = 32'h5; flit_in_data = 32'h0000_BEEF; flit_in_pri = 2'd2;
        push_tx(mk(32'h2, 32'h77, 2'd1), 1'b1);
        check("mis_ack", ack_out, 1);
        check("mis_flag", rx_misroute, 1);
        check("mis_rx_data", rx_data, 32'h0000_BEEF);
        check("mis_rx_addr", rx_addr, 32'h5);
        flit_in_addr = '0;
        for (int i = 0; i < 5; i++) step();
        req_in = 1'b0;
        check("mid_drop_cnt", rx_drop_cnt, 2);
        for (int k = 0; k < 10 && !req_out; k++) step();
        check("mid_req_active", req_out, 1);
        #2 rst_n = 1'b0;
        #1;
        exp_tx.delete(); exp_rx.delete(); attempt = 0; exp_tx_err = 1'b0;
        check("arst_req_out", req_out, 0);
        check("arst_tx_ready", tx_ready, 1);
        check("arst_rx_valid", rx_valid, 0);
        check("arst_ack_out", ack_out, 0);
        check("arst_tx_err", tx_err, 0);
        check("arst_misroute", rx_misroute, 0);
        check("arst_drop_cnt", rx_drop_cnt, 0);
        check("arst_flit_out_addr", flit_out_addr, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
